odometer_seq: RTL and testbench
===============================

ODOMETER_SEQ -- requirements
Module: odometer_seq

Interface
REQ-001 SHALL have port AC_STRESS_CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port RESETB, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port CMD_VALID, input, 1 bit: a measurement command is offered.
REQ-004 SHALL have port CMD_READY, output, 1 bit: the sequencer accepts a command; high only in IDLE.
REQ-005 SHALL have port CMD_AC_DC, input, 1 bit: stress mode for the command, 1=AC, 0=DC.
REQ-006 SHALL have port CMD_SEL, input, 2 bits: ring select; 00 INV, 01 NAND, 10 NOR, 11 illegal.
REQ-007 SHALL have port CMD_STRESS_CYC, input, 16 bits: number of stress cycles.
REQ-008 SHALL have port CMD_MEAS_CYC, input, 8 bits: MEAS_TRIG low window length in cycles.
REQ-009 SHALL have port ABORT, input, 1 bit: return to IDLE at the next edge.
REQ-010 SHALL have ports LOAD, START, AC_DC, SEL_INV, SEL_NAND, SEL_NOR, MEAS_TRIG, each output, 1 bit, each registered: the odometer control pins.
REQ-011 SHALL have port BF_COUNT, input, 12 bits: beat-frequency count from the odometer.
REQ-012 SHALL have port RESULT, output, 12 bits: captured BF_COUNT.
REQ-013 SHALL have port DELTA, output, 13 bits, two's complement: RESULT minus baseline.
REQ-014 SHALL have port RESULT_VALID, output, 1 bit: one-cycle pulse when RESULT and DELTA update.
REQ-015 SHALL have port ERR, output, 1 bit: one-cycle pulse when a command with CMD_SEL=11 is accepted.

Function
REQ-016 SHALL transfer a command when CMD_VALID and CMD_READY are both high at a rising edge, latching all CMD_* fields.
REQ-017 SHALL implement states IDLE, CONFIG, STRESS, MEAS, CAPTURE.
- IDLE -> CONFIG on a legal transfer.
- CONFIG -> STRESS after 2 cycles.
- STRESS -> MEAS when the stress counter reaches 0.
- MEAS -> CAPTURE when the MEAS window expires.
- CAPTURE -> IDLE after 1 cycle.
REQ-018 SHALL drive LOAD low for the first CONFIG cycle and high otherwise, with SEL_*/AC_DC valid from the first CONFIG cycle.
REQ-019 SHALL decode CMD_SEL to a one-hot SEL_INV/SEL_NAND/SEL_NOR, held until the next accepted command.
REQ-020 SHALL hold START high in STRESS and low in all other states.
REQ-021 SHALL hold MEAS_TRIG high in all states except MEAS, where it is low for exactly max(CMD_MEAS_CYC,1) cycles.
REQ-022 SHALL load the 16-bit stress counter with CMD_STRESS_CYC and decrement it once per STRESS cycle.
- CMD_STRESS_CYC=0: one STRESS cycle only.
- CMD_STRESS_CYC=FFFF: must not wrap.
REQ-023 SHALL sample BF_COUNT in CAPTURE into RESULT and pulse RESULT_VALID in the same cycle RESULT changes.
REQ-024 SHALL store the first RESULT after reset as the baseline and report DELTA=0 for it; subsequent DELTA = {1'b0,RESULT} - {1'b0,baseline}.
REQ-025 SHALL, for a command with CMD_SEL=11, pulse ERR, stay in IDLE, and leave all outputs unchanged.
REQ-026 SHALL, on ABORT in any non-IDLE state, enter IDLE next cycle with START=0, MEAS_TRIG=1, LOAD=1, no RESULT_VALID, and counters cleared; baseline is retained.
REQ-027 SHALL give a simultaneous ABORT and transfer in IDLE priority to ABORT, so no command is accepted.

Reset
REQ-028 SHALL, with RESETB low at a rising edge, set:
- state to IDLE;
- LOAD=0, START=0, AC_DC=0, SEL_*=0, MEAS_TRIG=1;
- RESULT=0, DELTA=0, RESULT_VALID=0, ERR=0;
- baseline invalid; counters 0.
REQ-029 SHALL, after RESETB deasserts, raise LOAD to 1 on the first edge and assert CMD_READY from the first edge.
REQ-030 SHALL abandon any operation in progress when RESETB goes low mid-operation, with no RESULT_VALID.

Structure
REQ-031 SHALL place the state enumeration, the SEL encodings, and the widths (BF=12, STRESS=16, MEAS=8) in the shared package odometer_pkg.
REQ-032 SHALL instantiate one sub-module, odometer_seq_cnt: a loadable down-counter with zero flag, used for both the stress and MEAS counts.

Verification
REQ-033 SHALL cover: reset -> MEAS_TRIG=1, LOAD=0 then 1, CMD_READY=1, RESULT=0.
REQ-034 SHALL cover: command SEL=01, AC_DC=1, STRESS=10, MEAS=4, BF_COUNT=0x123 -> SEL_NAND=1, START high 10 cycles, MEAS_TRIG low 4 cycles, RESULT=0x123, DELTA=0.
REQ-035 SHALL cover: a second command with BF_COUNT=0x100 -> RESULT=0x100, DELTA=-35 (0x1FDD).
REQ-036 SHALL cover: CMD_SEL=11 -> ERR pulse, state IDLE, START never asserted.
REQ-037 SHALL cover: ABORT during STRESS cycle 5 -> IDLE next cycle, START=0, no RESULT_VALID.
REQ-038 SHALL cover: STRESS=0, MEAS=0 -> one START cycle, one MEAS_TRIG-low cycle, RESULT_VALID pulse.

Source files
------------

// File: rtl/odometer_pkg.sv
// Shared types and widths for the odometer measurement sequencer.
// Holds the state encoding, ring-select codes and datapath widths.
package odometer_pkg;

  localparam int BF_W     = 12;
  localparam int STRESS_W = 16;
  localparam int MEAS_W   = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_STRESS,
    S_MEAS,
    S_CAPTURE
  } state_t;

  typedef enum logic [1:0] {
    SEL_CODE_INV  = 2'b00,
    SEL_CODE_NAND = 2'b01,
    SEL_CODE_NOR  = 2'b10,
    SEL_CODE_BAD  = 2'b11
  } sel_t;

  // Bit 0 = INV, bit 1 = NAND, bit 2 = NOR; the illegal code decodes to none.
  function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
    case (sel)
      SEL_CODE_INV:  sel_onehot = 3'b001;
      SEL_CODE_NAND: sel_onehot = 3'b010;
      SEL_CODE_NOR:  sel_onehot = 3'b100;
      default:       sel_onehot = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/odometer_seq_cnt.sv
// Loadable, saturating down-counter with zero flag, shared by the
// stress-cycle and measurement-window phases of the sequencer.
module odometer_seq_cnt
  import odometer_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                load,
  input  logic [STRESS_W-1:0] load_val,
  input  logic                dec,
  output logic [STRESS_W-1:0] count,
  output logic                zero
);

  assign zero = (count == '0);

  // Decrement saturates at zero so a maximum load can never wrap.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - STRESS_W'(1);
    end
  end

endmodule

// File: rtl/odometer_seq.sv
// Odometer stress/measure sequencer: accepts a command, drives the odometer
// control pins through CONFIG/STRESS/MEAS, then captures BF_COUNT and a delta.
module odometer_seq
  import odometer_pkg::*;
(
  input  logic                AC_STRESS_CLK,
  input  logic                RESETB,
  input  logic                CMD_VALID,
  output logic                CMD_READY,
  input  logic                CMD_AC_DC,
  input  logic [1:0]          CMD_SEL,
  input  logic [STRESS_W-1:0] CMD_STRESS_CYC,
  input  logic [MEAS_W-1:0]   CMD_MEAS_CYC,
  input  logic                ABORT,
  output logic                LOAD,
  output logic                START,
  output logic                AC_DC,
  output logic                SEL_INV,
  output logic                SEL_NAND,
  output logic                SEL_NOR,
  output logic                MEAS_TRIG,
  input  logic [BF_W-1:0]     BF_COUNT,
  output logic [BF_W-1:0]     RESULT,
  output logic [BF_W:0]       DELTA,
  output logic                RESULT_VALID,
  output logic                ERR
);

  state_t                state;
  logic                  cfg_first;
  logic [MEAS_W-1:0]     meas_cyc;
  logic [BF_W-1:0]       baseline;
  logic                  base_valid;

  logic                  accept;
  logic                  legal;
  logic                  abort_op;
  logic                  phase_last;
  logic                  cnt_clr;
  logic                  cnt_load;
  logic                  cnt_dec;
  logic [STRESS_W-1:0]   cnt_val;
  logic [STRESS_W-1:0]   cnt_count;
  logic                  cnt_zero;

  odometer_seq_cnt u_cnt (
    .clk      (AC_STRESS_CLK),
    .rst_n    (RESETB),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .count    (cnt_count),
    .zero     (cnt_zero)
  );

  // A phase of N cycles ends when the count is 1, or at once when loaded with 0.
  always_comb begin
    accept     = CMD_VALID && CMD_READY && !ABORT;
    legal      = accept && (CMD_SEL != SEL_CODE_BAD);
    abort_op   = ABORT && (state != S_IDLE);
    phase_last = cnt_zero || (cnt_count == STRESS_W'(1));
    cnt_clr    = abort_op;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_val    = '0;
    if (legal) begin
      cnt_load = 1'b1;
      cnt_val  = CMD_STRESS_CYC;
    end else if (!abort_op && state == S_STRESS) begin
      if (phase_last) begin
        cnt_load = 1'b1;
        cnt_val  = STRESS_W'(meas_cyc);
      end else begin
        cnt_dec = 1'b1;
      end
    end else if (!abort_op && state == S_MEAS && !phase_last) begin
      cnt_dec = 1'b1;
    end
  end

  // NOTE: all state and outputs use <= so every register samples the values
  // from before this edge; mixing in = here would create ordering races.
  always_ff @(posedge AC_STRESS_CLK) begin
    if (!RESETB) begin
      state        <= S_IDLE;
      cfg_first    <= 1'b0;
      meas_cyc     <= '0;
      baseline     <= '0;
      base_valid   <= 1'b0;
      CMD_READY    <= 1'b0;
      LOAD         <= 1'b0;
      START        <= 1'b0;
      AC_DC        <= 1'b0;
      SEL_INV      <= 1'b0;
      SEL_NAND     <= 1'b0;
      SEL_NOR      <= 1'b0;
      MEAS_TRIG    <= 1'b1;
      RESULT       <= '0;
      DELTA        <= '0;
      RESULT_VALID <= 1'b0;
      ERR          <= 1'b0;
    end else begin
      RESULT_VALID <= 1'b0;
      ERR          <= 1'b0;
      if (abort_op) begin
        state     <= S_IDLE;
        cfg_first <= 1'b0;
        CMD_READY <= 1'b1;
        LOAD      <= 1'b1;
        START     <= 1'b0;
        MEAS_TRIG <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            LOAD      <= 1'b1;
            CMD_READY <= 1'b1;
            if (legal) begin
              state                        <= S_CONFIG;
              cfg_first                    <= 1'b1;
              CMD_READY                    <= 1'b0;
              LOAD                         <= 1'b0;
              AC_DC                        <= CMD_AC_DC;
              meas_cyc                     <= CMD_MEAS_CYC;
              {SEL_NOR, SEL_NAND, SEL_INV} <= sel_onehot(CMD_SEL);
            end else if (accept) begin
              ERR <= 1'b1;
            end
          end
          S_CONFIG: begin
            if (cfg_first) begin
              cfg_first <= 1'b0;
              LOAD      <= 1'b1;
            end else begin
              state <= S_STRESS;
              START <= 1'b1;
            end
          end
          S_STRESS: begin
            if (phase_last) begin
              state     <= S_MEAS;
              START     <= 1'b0;
              MEAS_TRIG <= 1'b0;
            end
          end
          S_MEAS: begin
            if (phase_last) begin
              state     <= S_CAPTURE;
              MEAS_TRIG <= 1'b1;
            end
          end
          S_CAPTURE: begin
            state        <= S_IDLE;
            CMD_READY    <= 1'b1;
            RESULT       <= BF_COUNT;
            RESULT_VALID <= 1'b1;
            if (!base_valid) begin
              baseline   <= BF_COUNT;
              base_valid <= 1'b1;
              DELTA      <= '0;
            end else begin
              DELTA <= {1'b0, BF_COUNT} - {1'b0, baseline};
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_odometer_seq.sv
// Scoreboard bench for odometer_seq: directed commands push expected
// results; a monitor pops and compares on every RESULT_VALID pulse.
module tb_odometer_seq;

  logic        AC_STRESS_CLK = 1'b0;
  logic        RESETB;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic        CMD_AC_DC;
  logic [1:0]  CMD_SEL;
  logic [15:0] CMD_STRESS_CYC;
  logic [7:0]  CMD_MEAS_CYC;
  logic        ABORT;
  logic        LOAD, START, AC_DC, SEL_INV, SEL_NAND, SEL_NOR, MEAS_TRIG;
  logic [11:0] BF_COUNT;
  logic [11:0] RESULT;
  logic [12:0] DELTA;
  logic        RESULT_VALID;
  logic        ERR;

  typedef struct {
    logic [11:0] result;
    logic [12:0] delta;
    int          start_n;
    int          meas_n;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   err_seen = 0;
  int   exp_err  = 0;
  int   start_n  = 0;
  int   meas_n   = 0;

  odometer_seq dut (
    .AC_STRESS_CLK  (AC_STRESS_CLK),
    .RESETB         (RESETB),
    .CMD_VALID      (CMD_VALID),
    .CMD_READY      (CMD_READY),
    .CMD_AC_DC      (CMD_AC_DC),
    .CMD_SEL        (CMD_SEL),
    .CMD_STRESS_CYC (CMD_STRESS_CYC),
    .CMD_MEAS_CYC   (CMD_MEAS_CYC),
    .ABORT          (ABORT),
    .LOAD           (LOAD),
    .START          (START),
    .AC_DC          (AC_DC),
    .SEL_INV        (SEL_INV),
    .SEL_NAND       (SEL_NAND),
    .SEL_NOR        (SEL_NOR),
    .MEAS_TRIG      (MEAS_TRIG),
    .BF_COUNT       (BF_COUNT),
    .RESULT         (RESULT),
    .DELTA          (DELTA),
    .RESULT_VALID   (RESULT_VALID),
    .ERR            (ERR)
  );

  always #5 AC_STRESS_CLK = ~AC_STRESS_CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got no event, expected one within 300 cycles", name);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 300; i++) begin
      @(negedge AC_STRESS_CLK);
      if (CMD_READY) return;
    end
    timeout("ready_timeout");
  endtask

  task automatic wait_start();
    for (int i = 0; i < 300; i++) begin
      @(negedge AC_STRESS_CLK);
      if (START) return;
    end
    timeout("start_timeout");
  endtask

  task automatic send(input logic ac, input logic [1:0] sel, input logic [15:0] st,
                      input logic [7:0] ms, input logic ab);
    wait_ready();
    CMD_AC_DC      = ac;
    CMD_SEL        = sel;
    CMD_STRESS_CYC = st;
    CMD_MEAS_CYC   = ms;
    ABORT          = ab;
    CMD_VALID      = 1'b1;
    @(posedge AC_STRESS_CLK);
    #1;
    CMD_VALID = 1'b0;
    ABORT     = 1'b0;
  endtask

  // Monitor: counts START-high and MEAS_TRIG-low cycles per command and
  // scores every RESULT_VALID pulse against the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge AC_STRESS_CLK);
      if (ERR) err_seen++;
      if (START) start_n++;
      if (!MEAS_TRIG) meas_n++;
      if (RESULT_VALID) begin
        if (exp_q.size() == 0) begin
          check("result_valid_unexpected", 32'(RESULT_VALID), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("result", 32'(RESULT), 32'(e.result));
          check("delta", 32'(DELTA), 32'(e.delta));
          check("start_cycles", start_n, e.start_n);
          check("meas_low_cycles", meas_n, e.meas_n);
        end
      end
      if (CMD_READY) begin
        start_n = 0;
        meas_n  = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESETB = 1'b0; CMD_VALID = 1'b0; CMD_AC_DC = 1'b0; CMD_SEL = 2'b00;
    CMD_STRESS_CYC = '0; CMD_MEAS_CYC = '0; ABORT = 1'b0; BF_COUNT = '0;

    // Reset values
    repeat (3) @(posedge AC_STRESS_CLK);
    @(negedge AC_STRESS_CLK);
    check("rst_meas_trig", 32'(MEAS_TRIG), 32'd1);
    check("rst_load", 32'(LOAD), 32'd0);
    check("rst_start", 32'(START), 32'd0);
    check("rst_result", 32'(RESULT), 32'd0);
    check("rst_delta", 32'(DELTA), 32'd0);
    check("rst_ready", 32'(CMD_READY), 32'd0);
    @(posedge AC_STRESS_CLK); #1;
    RESETB = 1'b1;
    @(negedge AC_STRESS_CLK);
    check("post_rst_load_before_edge", 32'(LOAD), 32'd0);
    @(negedge AC_STRESS_CLK);
    check("post_rst_load", 32'(LOAD), 32'd1);
    check("post_rst_ready", 32'(CMD_READY), 32'd1);

    // First command becomes the baseline
    BF_COUNT = 12'h123;
    exp_q.push_back('{12'h123, 13'h0000, 10, 4});
    send(1'b1, 2'b01, 16'd10, 8'd4, 1'b0);
    @(negedge AC_STRESS_CLK);
    check("cfg1_load", 32'(LOAD), 32'd0);
    check("cfg1_sel", 32'({SEL_NOR, SEL_NAND, SEL_INV}), 32'b010);
    check("cfg1_ac_dc", 32'(AC_DC), 32'd1);
    check("cfg1_ready", 32'(CMD_READY), 32'd0);
    @(negedge AC_STRESS_CLK);
    check("cfg2_load", 32'(LOAD), 32'd1);
    check("cfg2_start", 32'(START), 32'd0);
    wait_ready();

    // Second command: negative delta (0x100 - 0x123 = -35)
    BF_COUNT = 12'h100;
    exp_q.push_back('{12'h100, 13'h1FDD, 3, 2});
    send(1'b0, 2'b00, 16'd3, 8'd2, 1'b0);
    wait_ready();

    // Illegal select: ERR pulse, nothing else moves
    exp_err++;
    send(1'b1, 2'b11, 16'd7, 8'd1, 1'b0);
    @(negedge AC_STRESS_CLK);
    check("bad_err", 32'(ERR), 32'd1);
    check("bad_ready", 32'(CMD_READY), 32'd1);
    check("bad_sel_kept", 32'({SEL_NOR, SEL_NAND, SEL_INV}), 32'b001);
    check("bad_ac_dc_kept", 32'(AC_DC), 32'd0);
    repeat (3) @(negedge AC_STRESS_CLK);
    check("bad_start", 32'(START), 32'd0);
    check("bad_result_kept", 32'(RESULT), 32'h100);

    // Abort in STRESS cycle 5
    BF_COUNT = 12'h3FF;
    send(1'b1, 2'b10, 16'd20, 8'd3, 1'b0);
    wait_start();
    repeat (4) @(posedge AC_STRESS_CLK);
    #1;
    check("abort_start_before", 32'(START), 32'd1);
    ABORT = 1'b1;
    @(posedge AC_STRESS_CLK); #1;
    ABORT = 1'b0;
    @(negedge AC_STRESS_CLK);
    check("abort_start", 32'(START), 32'd0);
    check("abort_ready", 32'(CMD_READY), 32'd1);
    check("abort_meas_trig", 32'(MEAS_TRIG), 32'd1);
    check("abort_load", 32'(LOAD), 32'd1);
    repeat (5) @(negedge AC_STRESS_CLK);

    // Zero-length stress and window; baseline survives the abort
    BF_COUNT = 12'h130;
    exp_q.push_back('{12'h130, 13'h000D, 1, 1});
    send(1'b0, 2'b00, 16'd0, 8'd0, 1'b0);
    wait_ready();

    // ABORT together with a transfer in IDLE wins
    send(1'b0, 2'b10, 16'd5, 8'd5, 1'b1);
    @(negedge AC_STRESS_CLK);
    check("abort_xfer_ready", 32'(CMD_READY), 32'd1);
    check("abort_xfer_sel", 32'({SEL_NOR, SEL_NAND, SEL_INV}), 32'b001);
    check("abort_xfer_load", 32'(LOAD), 32'd1);
    repeat (3) @(negedge AC_STRESS_CLK);
    check("abort_xfer_start", 32'(START), 32'd0);

    // Reset mid-operation, then a fresh baseline
    BF_COUNT = 12'h222;
    send(1'b1, 2'b01, 16'd8, 8'd2, 1'b0);
    wait_start();
    @(posedge AC_STRESS_CLK); #1;
    RESETB = 1'b0;
    @(posedge AC_STRESS_CLK); #1;
    RESETB = 1'b1;
    @(negedge AC_STRESS_CLK);
    check("midrst_load", 32'(LOAD), 32'd0);
    check("midrst_start", 32'(START), 32'd0);
    check("midrst_meas_trig", 32'(MEAS_TRIG), 32'd1);
    check("midrst_result", 32'(RESULT), 32'd0);
    check("midrst_sel", 32'({SEL_NOR, SEL_NAND, SEL_INV}), 32'b000);

    BF_COUNT = 12'h055;
    exp_q.push_back('{12'h055, 13'h0000, 2, 1});
    send(1'b0, 2'b10, 16'd2, 8'd1, 1'b0);
    @(negedge AC_STRESS_CLK);
    check("cmd6_sel", 32'({SEL_NOR, SEL_NAND, SEL_INV}), 32'b100);
    wait_ready();

    repeat (5) @(negedge AC_STRESS_CLK);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("err_pulses", err_seen, exp_err);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
